alu_multicycle: RTL and testbench

- Parametrised, handshaked successor to the single-cycle ALU.
- Keeps the 4-bit operation encoding and the Zero flag; generalises operand width via `XLEN`.
- Registers all results behind valid/ready.
- Replaces combinational `*` and `%` with iterative shift-add multiply and restoring divide, and adds unsigned divide and a flush.
- Sits between decode/operand-read and writeback in the execute stage of the RISC-V core.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_divider.sv | 68 ++++++
 rtl/alu_multicycle.sv | 179 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encoding, FSM states
// and the helpers that decide how an opcode is executed.
package alu_pkg;

  // Opcode encoding, unchanged from the single-cycle ALU (DIVU is new)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NAND = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SMT  = 4'b1000;
  localparam logic [3:0] ALU_MUL  = 4'b1001;
  localparam logic [3:0] ALU_REM  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_NOTA = 4'b1101;
  localparam logic [3:0] ALU_NOTB = 4'b1110;
  localparam logic [3:0] ALU_DIVU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

  // Opcodes that normally take XLEN iteration cycles
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_REM) || (op == ALU_DIVU);
  endfunction

  // Opcodes that go through the divider (and can divide by zero)
  function automatic logic is_divide(input logic [3:0] op);
    return (op == ALU_REM) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider. One quotient bit per cycle, XLEN
// cycles per division. `done` is high during the final iteration cycle and
// `quotient`/`remainder` carry the finished values in that same cycle, so the
// caller can register them on the edge that ends the iteration.
module alu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic            active;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;

  // One restoring step: shift in the next dividend bit, try to subtract
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, dsr_q};
    rem_n = diff[XLEN-1:0];
    quo_n = {quo_q[XLEN-2:0], 1'b1};
    if (diff[XLEN]) begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign done      = active && (&cnt);
  assign quotient  = quo_n;
  assign remainder = rem_n;

  // Load on start, then iterate until the counter wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      dsr_q  <= divisor;
    end else if (active) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt   <= cnt + 1'b1;
      if (&cnt) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes. Simple ops finish in one
// cycle; MUL uses a shift-add loop and REM/DIVU a restoring divider, both
// XLEN cycles. Results are registered and held until consumed.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// && !flush; a result transfers on a rising edge where out_valid && out_ready.
// Result/Zero/DivByZero never change while out_valid && !out_ready.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      ALUControl,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            DivByZero,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  alu_state_t      state;
  alu_state_t      state_next;
  alu_state_t      launch_state;
  logic            accept;
  logic            div_zero;
  logic [XLEN-1:0] simple_res;

  logic [XLEN-1:0] mul_cand;
  logic [XLEN-1:0] mul_plier;
  logic [XLEN-1:0] mul_acc;
  logic [XLEN-1:0] mul_acc_next;
  logic [SHW-1:0]  mul_cnt;
  logic            mul_last;

  logic [3:0]      op_q;
  logic            div_start;
  logic            div_done;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;

  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            dbz_q;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready && !flush;
  assign div_zero  = is_divide(ALUControl) && (B == '0);
  assign div_start = accept && (launch_state == DIV);
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign DivByZero = dbz_q;

  // Single-cycle datapath; divide-by-zero results are produced here too
  always_comb begin
    simple_res = '0;
    case (ALUControl)
      ALU_AND:  simple_res = A & B;
      ALU_OR:   simple_res = A | B;
      ALU_NAND: simple_res = ~(A & B);
      ALU_NOR:  simple_res = ~(A | B);
      ALU_XOR:  simple_res = A ^ B;
      ALU_ADD:  simple_res = A + B;
      ALU_SUB:  simple_res = A - B;
      ALU_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SMT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(A) > $signed(B))};
      ALU_SLL:  simple_res = A << B[SHW-1:0];
      ALU_SRL:  simple_res = A >> B[SHW-1:0];
      ALU_NOTA: simple_res = ~A;
      ALU_NOTB: simple_res = ~B;
      ALU_REM:  simple_res = '0;
      ALU_DIVU: simple_res = '1;
      default:  simple_res = '0;
    endcase
  end

  // Where an accepted request goes: straight to DONE or into an iteration
  always_comb begin
    launch_state = DONE;
    if (is_iterative(ALUControl) && !div_zero) begin
      launch_state = (ALUControl == ALU_MUL) ? MUL : DIV;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = launch_state;
        MUL:     if (mul_last) state_next = DONE;
        DIV:     if (div_done) state_next = DONE;
        DONE:    if (out_ready) state_next = accept ? launch_state : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Shift-add step: add the multiplicand when the current multiplier bit is set
  assign mul_acc_next = mul_plier[0] ? (mul_acc + mul_cand) : mul_acc;
  assign mul_last     = (state == MUL) && (&mul_cnt);

  // Multiplier registers: load on accept, one multiplier bit per MUL cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cand  <= '0;
      mul_plier <= '0;
      mul_acc   <= '0;
      mul_cnt   <= '0;
      op_q      <= '0;
    end else if (accept) begin
      mul_cand  <= A;
      mul_plier <= B;
      mul_acc   <= '0;
      mul_cnt   <= '0;
      op_q      <= ALUControl;
    end else if (state == MUL) begin
      mul_cand  <= mul_cand << 1;
      mul_plier <= mul_plier >> 1;
      mul_acc   <= mul_acc_next;
      mul_cnt   <= mul_cnt + 1'b1;
    end
  end

  alu_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (A),
    .divisor   (B),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Output registers: written only on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else if (!flush) begin
      if (accept && (launch_state == DONE)) begin
        result_q <= simple_res;
        zero_q   <= (simple_res == '0);
        dbz_q    <= div_zero;
      end else if (mul_last) begin
        result_q <= mul_acc_next;
        zero_q   <= (mul_acc_next == '0);
        dbz_q    <= 1'b0;
      end else if ((state == DIV) && div_done) begin
        result_q <= (op_q == ALU_REM) ? div_rem : div_quo;
        zero_q   <= (((op_q == ALU_REM) ? div_rem : div_quo) == '0);
        dbz_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: scenario tasks drive requests, a reference
// model fills an expected queue at each accept, and the output monitor
// pops and compares on every result handshake.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int SHW  = $clog2(XLEN);
  localparam int W    = XLEN + 1;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [3:0]      ALUControl;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Result;
  logic            Zero;
  logic            DivByZero;
  logic            busy;
  logic [1:0]      state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  alu_multicycle #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Zero       (Zero),
    .DivByZero  (DivByZero),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- reference model: {DivByZero, Result} ----------------
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic            z;
    logic [SHW-1:0]  sh;
    r  = '0;
    z  = 1'b0;
    sh = b[SHW-1:0];
    case (op)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_NAND: r = ~(a & b);
      ALU_NOR:  r = ~(a | b);
      ALU_XOR:  r = a ^ b;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SMT:  r = {{(XLEN-1){1'b0}}, ($signed(a) > $signed(b))};
      ALU_MUL:  r = a * b;
      ALU_REM:  if (b == '0) begin z = 1'b1; r = '0; end else r = a % b;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_NOTA: r = ~a;
      ALU_NOTB: r = ~b;
      ALU_DIVU: if (b == '0) begin z = 1'b1; r = '1; end else r = a / b;
      default:  r = '0;
    endcase
    return {z, r};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_output got result=%h dbz=%b required=no output", Result, DivByZero);
      end else begin
        mon_e = exp_q.pop_front();
        if ({DivByZero, Result} !== mon_e || Zero !== (mon_e[XLEN-1:0] == '0)) begin
          failures++;
          $display("FAIL sb_result got result=%h zero=%b dbz=%b required result=%h zero=%b dbz=%b",
                   Result, Zero, DivByZero, mon_e[XLEN-1:0], (mon_e[XLEN-1:0] == '0), mon_e[XLEN]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call between a rising edge and the following falling edge; returns at
  // accept edge + 1 time unit with the number of cycles waited.
  task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    ALUControl = op;
    A          = a;
    B          = b;
    in_valid   = 1'b1;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = in_ready && !flush;
      waits++;
      @(posedge clk);
    end
    checks++;
    if (acc) exp_q.push_back(model(op, a, b));
    else begin
      failures++;
      $display("FAIL send_timeout op=%b got no accept required accept within 200 cycles", op);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUControl = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (Result !== '0) begin failures++; $display("FAIL reset_result got %h required 0", Result); end
    checks++; if (Zero !== 1'b1) begin failures++; $display("FAIL reset_zero got %b required 1", Zero); end
    checks++; if (DivByZero !== 1'b0) begin failures++; $display("FAIL reset_dbz got %b required 0", DivByZero); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got %0d required %0d", state_dbg, IDLE); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_wrap();
    int w;
    out_ready = 1'b1;
    send(ALU_ADD, '1, 32'd1, w);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_latency got out_valid=%b required 1", out_valid); end
    checks++; if (Result !== '0 || Zero !== 1'b1) begin failures++; $display("FAIL add_wrap got result=%h zero=%b required 0/1", Result, Zero); end
    drain();
  endtask

  task automatic test_mul();
    int w;
    int bad;
    drain();
    send(ALU_MUL, 32'd123456, 32'd789, w);
    bad = 0;
    for (int i = 1; i <= XLEN; i++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL mul_busy_window got %0d bad cycles required 0", bad); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mul_latency got out_valid=%b busy=%b required 1/0", out_valid, busy); end
    checks++; if (Result !== 32'd97406784) begin failures++; $display("FAIL mul_result got %h required %h", Result, 32'd97406784); end
    drain();
  endtask

  task automatic test_div();
    logic [3:0]      ops[2];
    logic [XLEN-1:0] res[2];
    int w;
    int bad;
    ops[0] = ALU_DIVU; res[0] = 32'd14;
    ops[1] = ALU_REM;  res[1] = 32'd2;
    for (int k = 0; k < 2; k++) begin
      drain();
      send(ops[k], 32'd100, 32'd7, w);
      bad = 0;
      for (int i = 1; i <= XLEN; i++) begin
        @(negedge clk);
        if (!(busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0)) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL div_busy_window op=%b got %0d bad cycles required 0", ops[k], bad); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || Result !== res[k] || Zero !== 1'b0 || DivByZero !== 1'b0) begin
        failures++;
        $display("FAIL div_result op=%b got valid=%b result=%h zero=%b dbz=%b required 1/%h/0/0",
                 ops[k], out_valid, Result, Zero, DivByZero, res[k]);
      end
    end
    drain();
  endtask

  task automatic test_div_zero();
    logic [3:0]      ops[2];
    logic [XLEN-1:0] res[2];
    int w;
    ops[0] = ALU_REM;  res[0] = '0;
    ops[1] = ALU_DIVU; res[1] = '1;
    for (int k = 0; k < 2; k++) begin
      drain();
      send(ops[k], 32'd5, '0, w);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || Result !== res[k] || DivByZero !== 1'b1 || Zero !== (res[k] == '0)) begin
        failures++;
        $display("FAIL div_zero op=%b got valid=%b result=%h zero=%b dbz=%b required 1/%h/%b/1",
                 ops[k], out_valid, Result, Zero, DivByZero, res[k], (res[k] == '0));
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    int bad;
    logic [XLEN-1:0] xa;
    logic [XLEN-1:0] xb;
    drain();
    out_ready = 1'b0;
    send(ALU_SLT, -32'sd3, 32'd2, w);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && Result === 32'd1 && in_ready === 1'b0 && Zero === 1'b0)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got %0d bad cycles required 0", bad); end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    xa = $urandom;
    xb = $urandom;
    send(ALU_XOR, xa, xb, w);
    checks++; if (w != 1) begin failures++; $display("FAIL bp_same_cycle got %0d wait cycles required 1", w); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || Result !== (xa ^ xb)) begin failures++; $display("FAIL bp_xor got valid=%b result=%h required 1/%h", out_valid, Result, xa ^ xb); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0] simple_ops[13];
    int w;
    int slow;
    simple_ops = '{ALU_AND, ALU_OR, ALU_NAND, ALU_NOR, ALU_XOR, ALU_ADD, ALU_SUB,
                   ALU_SLT, ALU_SMT, ALU_SLL, ALU_SRL, ALU_NOTA, ALU_NOTB};
    drain();
    slow = 0;
    for (int i = 0; i < 26; i++) begin
      send(simple_ops[$urandom_range(0, 12)], $urandom, $urandom, w);
      if (w != 1) slow++;
    end
    checks++; if (slow != 0) begin failures++; $display("FAIL b2b_throughput got %0d stalled requests required 0", slow); end
    drain();
  endtask

  task automatic test_random_mix();
    int w;
    logic [XLEN-1:0] b;
    drain();
    for (int i = 0; i < 16; i++) begin
      b = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      send(4'($urandom_range(0, 15)), $urandom, b, w);
    end
    drain();
  endtask

  task automatic test_flush();
    int w;
    int bad;
    drain();
    // flush mid-MUL
    send(ALU_MUL, $urandom, $urandom, w);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(exp_q.pop_back());
    checks++; if (state_dbg !== IDLE || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_mul got state=%0d busy=%b valid=%b required %0d/0/0", state_dbg, busy, out_valid, IDLE); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL flush_mul_no_output got %0d valid cycles required 0", bad); end
    // request presented together with flush is not accepted
    @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; ALUControl = ALU_ADD; A = 32'd1; B = 32'd1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || state_dbg !== IDLE) begin failures++; $display("FAIL flush_blocks_accept got valid=%b state=%0d required 0/%0d", out_valid, state_dbg, IDLE); end
    // flush and out_ready together in DONE: consumed once, then gone
    @(posedge clk);
    #1;
    send(ALU_ADD, 32'd3, 32'd4, w);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL flush_done got valid=%b pending=%0d required 0/0", out_valid, exp_q.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_div();
    int w;
    int bad;
    drain();
    send(ALU_DIVU, $urandom, 32'd3, w);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    checks++;
    if (out_valid !== 1'b0 || Result !== '0 || Zero !== 1'b1 || DivByZero !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL reset_mid_div got valid=%b result=%h zero=%b dbz=%b busy=%b required 0/0/1/0/0",
               out_valid, Result, Zero, DivByZero, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_mid_div_quiet got %0d bad cycles required 0", bad); end
    @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_add_wrap();
    test_mul();
    test_div();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_random_mix();
    test_flush();
    test_reset_mid_div();
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_queue got %0d pending required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
